// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM state encoding,
// grant identity and the round-robin selection helper.
package cacheline_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    // Pick the requester to grant. Under contention the side that was
    // not served last wins; otherwise the only requester wins.
    function automatic arb_grant_t rr_pick(
        input logic       req_i,
        input logic       req_d,
        input arb_grant_t last
    );
        if (req_d && (!req_i || last == GRANT_I)) begin
            return GRANT_D;
        end
        return GRANT_I;
    endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Arbitrates the single physical-memory line port between the I-cache
// (reads only) and the D-cache (reads and writebacks), one at a time.
// Ports:
//   clk, rst                  clock, async active-high reset
//   i_read/i_addr             I-cache request; i_rdata/i_resp back
//   d_read/d_write/d_addr/
//   d_wdata                   D-cache request; d_rdata/d_resp back
//   pmem_read/pmem_write/
//   pmem_addr/pmem_wdata      registered request to the line adaptor
//   pmem_rdata/pmem_resp      adaptor completion
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    arb_grant_t        last_q,  last_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wr_q,    wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic       req_i;
    logic       req_d;
    arb_grant_t pick;

    assign req_i = i_read;
    assign req_d = d_read | d_write;
    assign pick  = rr_pick(req_i, req_d, last_q);

    // State and latched transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GRANT_I;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state plus capture of the granted request. The memory side
    // only ever sees these latched copies, so requesters may change
    // their inputs freely once granted.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    last_d = pick;
                    if (pick == GRANT_D) begin
                        state_d = SERVE_D;
                        addr_d  = d_addr;
                        // A simultaneous read+write is treated as write.
                        wr_d    = d_write;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_addr;
                        wr_d    = 1'b0;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                // Gives the served cache a cycle to drop its request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: memory request from registers only; responses pass the
    // adaptor pulse through to whichever side currently holds the grant.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state_q)
            SERVE_I: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = ~wr_q;
                pmem_write = wr_q;
                d_resp     = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

    a_d_rw_excl: assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule
